// File: rtl/gcd_job_feeder_if.sv
// Operand-in / result-out stream bundle for the GCD job feeder.
interface gcd_job_feeder_if #(
  parameter int unsigned W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_err;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_err
  );

  // Feeder side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_err
  );
endinterface

// File: rtl/gcd_job_feeder.sv
// Buffers operand pairs, issues them one at a time to the GCD core,
// short-circuits zero operands and aborts jobs the core never finishes.
module gcd_job_feeder #(
  parameter int unsigned W       = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  gcd_job_feeder_if.slave          bus,
  output logic [W-1:0]             gcd_a,
  output logic [W-1:0]             gcd_b,
  output logic                     gcd_start,
  input  logic                     gcd_done,
  input  logic [W-1:0]             gcd_res,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } job_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, OUT} state_t;

  state_t             state;
  job_t               mem [DEPTH];
  job_t               head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TMR_W-1:0]   timer;
  logic               push;
  logic               pop;

  // Ready is a pure function of occupancy, so a same-cycle pop never unblocks a full FIFO
  assign bus.in_ready = (fifo_count != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (fifo_count != '0);
  assign head         = mem[rd_ptr];

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b};
    end
  end

  // Write pointer and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Job sequencer: pop, bypass or issue, wait for core with timeout, present result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      timer         <= '0;
      gcd_a         <= '0;
      gcd_b         <= '0;
      gcd_start     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      gcd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            gcd_a  <= head.a;
            gcd_b  <= head.b;
            if ((head.a == '0) || (head.b == '0)) begin
              // gcd(x,0) = x and gcd(0,0) = 0, both equal a|b
              bus.out_res   <= head.a | head.b;
              bus.out_err   <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= OUT;
            end else begin
              gcd_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= BUSY;
        end
        BUSY: begin
          // A done arriving on the final timer cycle still wins
          if (gcd_done) begin
            bus.out_res   <= gcd_res;
            bus.out_err   <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= OUT;
          end else if (timer == TMR_LAST) begin
            bus.out_res   <= '0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= OUT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_feeder.sv
// Self-checking bench for gcd_job_feeder with a behavioural GCD core.
module tb_gcd_job_feeder;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned T     = 16;
  localparam int          NJOB  = 2048;

  logic                  clk;
  logic                  rst;
  logic [W-1:0]          gcd_a;
  logic [W-1:0]          gcd_b;
  logic                  gcd_start;
  logic                  gcd_done;
  logic [W-1:0]          gcd_res;
  logic [$clog2(DEPTH):0] fifo_count;

  gcd_job_feeder_if #(.W(W)) bus ();

  gcd_job_feeder #(.W(W), .DEPTH(DEPTH), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
    .gcd_done(gcd_done), .gcd_res(gcd_res), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Job descriptors in core-issue order (written by stimulus, read by core model)
  int ja_arr [NJOB];
  int jb_arr [NJOB];
  int lat_arr[NJOB];
  int n_nz = 0;
  int stray_cnt = 0;

  // Core model bookkeeping
  int n_start = 0;
  int start_idx = 0;
  int core_bad = 0;
  int stray_seen = 0;

  int n_checks = 0;
  int n_pass = 0;

  function automatic int ref_gcd(input int x, input int y);
    for (int d = (1 << W) - 1; d >= 1; d--)
      if ((x % d == 0) && (y % d == 0)) return d;
    return 0;
  endfunction

  // lat = cycles after start until done is seen; 0 means the core never answers
  function automatic int exp_res(input int a, input int b, input int lat);
    if (a == 0 || b == 0) return a | b;
    if (lat >= 1 && lat <= int'(T)) return ref_gcd(a, b);
    return 0;
  endfunction

  function automatic int exp_err(input int a, input int b, input int lat);
    if (a == 0 || b == 0) return 0;
    return (lat >= 1 && lat <= int'(T)) ? 0 : 1;
  endfunction

  // Behavioural GCD core: answers each start after the job's latency
  initial begin : core_model
    int lat;
    int ja;
    int jb;
    gcd_done = 1'b0;
    gcd_res  = '0;
    forever begin
      @(negedge clk);
      gcd_done = 1'b0;
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_seen + 1;
        gcd_done   = 1'b1;
        gcd_res    = W'(15);
      end else if (gcd_start) begin
        n_start = n_start + 1;
        ja  = ja_arr[start_idx % NJOB];
        jb  = jb_arr[start_idx % NJOB];
        lat = lat_arr[start_idx % NJOB];
        start_idx = start_idx + 1;
        if (int'(gcd_a) != ja || int'(gcd_b) != jb) core_bad = core_bad + 1;
        if (lat > 0) begin
          repeat (lat) @(negedge clk);
          gcd_done = 1'b1;
          gcd_res  = W'(ref_gcd(ja, jb));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic note_job(input int a, input int b, input int lat);
    if (a != 0 && b != 0) begin
      ja_arr[n_nz % NJOB]  = a;
      jb_arr[n_nz % NJOB]  = b;
      lat_arr[n_nz % NJOB] = lat;
      n_nz = n_nz + 1;
    end
  endtask

  task automatic wait_out(output int got);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One job through an empty, idle feeder; returns the presented result
  task automatic run_job(input int a, input int b, input int lat,
                         output int r, output int e, output int got);
    note_job(a, b, lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = W'(a);
    bus.in_b = W'(b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(got);
    r = int'(bus.out_res);
    e = int'(bus.out_err);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  typedef struct { int a; int b; int lat; int res; int err; } vec_t;
  typedef struct { int res; int err; } res_t;

  vec_t vecs[9];
  res_t exp_q[$];

  initial begin : main
    int r, e, got, s0, acc, n, a, b, lat, li;
    res_t x;

    vecs[0] = '{12, 8,  5,     4, 0};
    vecs[1] = '{0,  9,  0,     9, 0};
    vecs[2] = '{0,  0,  0,     0, 0};
    vecs[3] = '{7,  0,  0,     7, 0};
    vecs[4] = '{15, 10, T,     5, 0};
    vecs[5] = '{9,  6,  0,     0, 1};
    vecs[6] = '{14, 7,  T + 1, 0, 1};
    vecs[7] = '{13, 13, 1,    13, 0};
    vecs[8] = '{1,  15, 3,     1, 0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_count", int'(fifo_count), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_start", int'(gcd_start), 0);
    check("rst_gcd_a", int'(gcd_a), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_res", int'(bus.out_res), 0);
    check("rst_out_err", int'(bus.out_err), 0);

    // Push-to-start latency with (12,8), core answers after 5 cycles
    s0 = n_start;
    note_job(12, 8, 5);
    bus.in_valid = 1'b1; bus.in_a = W'(12); bus.in_b = W'(8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lat_count_after_push", int'(fifo_count), 1);
    check("lat_start_early", int'(gcd_start), 0);
    @(negedge clk);
    check("lat_start_high", int'(gcd_start), 1);
    check("lat_gcd_a", int'(gcd_a), 12);
    check("lat_gcd_b", int'(gcd_b), 8);
    check("lat_count_after_pop", int'(fifo_count), 0);
    @(negedge clk);
    check("lat_start_one_cycle", int'(gcd_start), 0);
    check("lat_gcd_a_held", int'(gcd_a), 12);
    wait_out(got);
    check("lat_got", got, 1);
    check("lat_res", int'(bus.out_res), 4);
    check("lat_err", int'(bus.out_err), 0);
    check("lat_starts", n_start - s0, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("lat_valid_drop", int'(bus.out_valid), 0);

    // Zero bypass latency
    bus.in_valid = 1'b1; bus.in_a = W'(0); bus.in_b = W'(9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("zb_valid_early", int'(bus.out_valid), 0);
    @(negedge clk);
    check("zb_valid", int'(bus.out_valid), 1);
    check("zb_res", int'(bus.out_res), 9);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Table of single jobs
    foreach (vecs[i]) begin
      s0 = n_start;
      run_job(vecs[i].a, vecs[i].b, vecs[i].lat, r, e, got);
      check($sformatf("vec%0d_got", i), got, 1);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
      check($sformatf("vec%0d_starts", i), n_start - s0,
            (vecs[i].a != 0 && vecs[i].b != 0) ? 1 : 0);
    end

    // Fill: one job stuck in the core, DEPTH more queued, then a rejected push
    note_job(3, 6, 0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = W'((i == 0) ? 3 : 0);
      bus.in_b = W'((i == 0) ? 6 : i);
      if (bus.in_ready) acc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fill_accepted", acc, DEPTH + 1);
    check("fill_count", int'(fifo_count), DEPTH);
    check("fill_in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_out(got);
      check($sformatf("fill%0d_got", k), got, 1);
      check($sformatf("fill%0d_res", k), int'(bus.out_res), k);
      check($sformatf("fill%0d_err", k), int'(bus.out_err), (k == 0) ? 1 : 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;

    // Timeout length, then the next queued job issues normally
    s0 = n_start;
    note_job(9, 6, 0);
    note_job(10, 4, 2);
    bus.in_valid = 1'b1; bus.in_a = W'(9); bus.in_b = W'(6);
    @(negedge clk);
    bus.in_a = W'(10); bus.in_b = W'(4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !gcd_start; i++) @(negedge clk);
    check("to_start_seen", int'(gcd_start), 1);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_busy_cycles", n, T + 1);
    check("to_res", int'(bus.out_res), 0);
    check("to_err", int'(bus.out_err), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    wait_out(got);
    check("to_next_got", got, 1);
    check("to_next_res", int'(bus.out_res), 2);
    check("to_next_err", int'(bus.out_err), 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("to_starts", n_start - s0, 2);

    // Randomized traffic against the scoreboard
    for (int cyc = 0; cyc < 400 || (exp_q.size() != 0 && cyc < 6000); cyc++) begin
      @(negedge clk);
      if (cyc < 400 && $urandom_range(0, 9) < 6) begin
        a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
        b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
        li = int'($urandom_range(0, 9));
        if (li == 0)      lat = 0;
        else if (li == 1) lat = T;
        else if (li == 2) lat = T + int'($urandom_range(1, 2));
        else              lat = int'($urandom_range(1, 6));
        bus.in_valid = 1'b1;
        bus.in_a = W'(a);
        bus.in_b = W'(b);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (bus.in_valid && bus.in_ready) begin
        note_job(a, b, lat);
        exp_q.push_back('{exp_res(a, b, lat), exp_err(a, b, lat)});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_out", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("rnd_res", int'(bus.out_res), x.res);
          check("rnd_err", int'(bus.out_err), x.err);
        end
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rnd_drained", exp_q.size(), 0);
    check("core_operands", core_bad, 0);

    // Reset mid-BUSY with three queued jobs
    while (bus.out_valid || fifo_count != 0) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    repeat (T + 4) @(negedge clk);
    note_job(5, 10, 0);
    bus.in_valid = 1'b1; bus.in_a = W'(5); bus.in_b = W'(10);
    @(negedge clk);
    bus.in_a = W'(3); bus.in_b = W'(9);
    @(negedge clk);
    bus.in_a = W'(4); bus.in_b = W'(8);
    @(negedge clk);
    bus.in_a = W'(6); bus.in_b = W'(9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_queued", int'(fifo_count), 3);
    s0 = n_start;
    rst = 1'b1;
    #1;
    check("rr_count", int'(fifo_count), 0);
    check("rr_in_ready", int'(bus.in_ready), 1);
    check("rr_gcd_a", int'(gcd_a), 0);
    check("rr_gcd_b", int'(gcd_b), 0);
    check("rr_out_valid", int'(bus.out_valid), 0);
    check("rr_out_err", int'(bus.out_err), 0);
    @(negedge clk);
    rst = 1'b0;
    stray_cnt = stray_cnt + 1;
    repeat (6) @(negedge clk);
    check("rr_stray_valid", int'(bus.out_valid), 0);
    check("rr_stray_res", int'(bus.out_res), 0);
    check("rr_no_start", n_start - s0, 0);
    check("rr_count_after", int'(fifo_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
